// File: rtl/trng_apb_fetch_m03_pkg.sv
// Shared definitions for the TRNG APB fetch block.
//   APB bus widths, TRNG register map (STATUS/DATA offsets, ready bit),
//   fetch FSM state encoding and a saturating 8-bit increment helper.
package trng_apb_fetch_m03_pkg;

  localparam int APB_ADDR_WIDTH   = 32;
  localparam int APB_DATA_WIDTH   = 32;
  localparam int APB_STROBE_WIDTH = 4;

  localparam logic [APB_ADDR_WIDTH-1:0] STATUS_ADDR = 32'h0000_0000;
  localparam logic [APB_ADDR_WIDTH-1:0] DATA_ADDR   = 32'h0000_0004;
  localparam int                        READY_BIT   = 0;

  typedef enum logic [2:0] {
    IDLE,
    ST_SETUP,
    ST_ACCESS,
    DT_SETUP,
    DT_ACCESS
  } fetch_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trng_apb_fetch_m03_if.sv
// APB bus between the fetch master and the TRNG wrapper slave.
//   master: drives paddr/pwdata/pprot/psel/penable/pwrite/pstrb,
//           receives pready/pslverr/prdata.
//   slave:  the mirror image.
interface trng_apb_fetch_m03_if;
  import trng_apb_fetch_m03_pkg::*;

  logic [APB_ADDR_WIDTH-1:0]   paddr_03;
  logic [APB_DATA_WIDTH-1:0]   pwdata_03;
  logic [2:0]                  pprot_03;
  logic                        psel_03;
  logic                        penable_03;
  logic                        pwrite_03;
  logic [APB_STROBE_WIDTH-1:0] pstrb_03;
  logic                        pready_03;
  logic                        pslverr_03;
  logic [APB_DATA_WIDTH-1:0]   prdata_03;

  modport master (
    output paddr_03, pwdata_03, pprot_03, psel_03, penable_03, pwrite_03, pstrb_03,
    input  pready_03, pslverr_03, prdata_03
  );

  modport slave (
    input  paddr_03, pwdata_03, pprot_03, psel_03, penable_03, pwrite_03, pstrb_03,
    output pready_03, pslverr_03, prdata_03
  );

endinterface

// File: rtl/trng_rnd_fifo.sv
// Synchronous random-word FIFO with a registered head word.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full)
//   pop        : drop the head word (ignored when empty)
//   head       : registered head word, stable until popped
//   valid      : FIFO non-empty
//   level      : occupancy, 0..DEPTH
module trng_rnd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic          push_eff, pop_eff;

  assign push_eff = push && (level != LW'(DEPTH));
  assign pop_eff  = pop && (level != '0);
  assign rd_ptr_n = pop_eff ? rd_ptr + PW'(1) : rd_ptr;
  assign valid    = (level != '0);

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  // The head register is loaded with whatever will sit at rd_ptr next
  // cycle; when that slot is the one being written now, bypass the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      if (push_eff) wr_ptr <= wr_ptr + PW'(1);
      if (push_eff && (wr_ptr == rd_ptr_n)) head <= push_data;
      else                                   head <= mem[rd_ptr_n];
      case ({push_eff, pop_eff})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trng_apb_fetch_m03.sv
// APB master that polls the TRNG STATUS register, reads DATA when the
// ready bit is set, and buffers the words for a valid/ready consumer.
//   pclk_03, preset_03 : clock, asynchronous active-high reset
//   fetch_en           : keep polling/fetching while high
//   apb                : APB master port (read-only; write side tied to 0)
//   rnd_data/rnd_valid/rnd_ready : random-word stream
//   fifo_level         : buffer occupancy
//   err_cnt            : saturating count of slave errors and timeouts
//   timeout_o          : sticky timeout flag
module trng_apb_fetch_m03
  import trng_apb_fetch_m03_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                        pclk_03,
  input  logic                        preset_03,
  input  logic                        fetch_en,
  trng_apb_fetch_m03_if.master        apb,
  output logic [APB_DATA_WIDTH-1:0]   rnd_data,
  output logic                        rnd_valid,
  input  logic                        rnd_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  err_cnt,
  output logic                        timeout_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  fetch_state_t  state, state_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          push, err_evt, tmo_evt;

  // APB outputs decode straight from the state register so an async
  // reset drops psel/penable without waiting for a clock edge.
  assign apb.psel_03    = (state != IDLE);
  assign apb.penable_03 = (state == ST_ACCESS) || (state == DT_ACCESS);
  assign apb.paddr_03   = ((state == ST_SETUP) || (state == ST_ACCESS)) ? STATUS_ADDR :
                          ((state == DT_SETUP) || (state == DT_ACCESS)) ? DATA_ADDR : '0;
  assign apb.pwdata_03  = '0;
  assign apb.pprot_03   = 3'b000;
  assign apb.pwrite_03  = 1'b0;
  assign apb.pstrb_03   = '0;

  always_ff @(posedge pclk_03 or posedge preset_03) begin
    if (preset_03) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      err_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      state   <= state_n;
      tmo_cnt <= tmo_cnt_n;
      if (err_evt) err_cnt   <= sat_inc8(err_cnt);
      if (tmo_evt) timeout_o <= 1'b1;
    end
  end

  // A fetch only starts with a free FIFO slot, so the DATA push can never
  // meet a full buffer. pready wins over timeout on the last ACCESS cycle.
  always_comb begin
    state_n   = state;
    tmo_cnt_n = tmo_cnt;
    push      = 1'b0;
    err_evt   = 1'b0;
    tmo_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en && (fifo_level < LW'(FIFO_DEPTH))) state_n = ST_SETUP;
      end
      ST_SETUP: begin
        tmo_cnt_n = '0;
        state_n   = ST_ACCESS;
      end
      DT_SETUP: begin
        tmo_cnt_n = '0;
        state_n   = DT_ACCESS;
      end
      ST_ACCESS, DT_ACCESS: begin
        if (apb.pready_03) begin
          state_n = IDLE;
          if (apb.pslverr_03)           err_evt = 1'b1;
          else if (state == DT_ACCESS)  push    = 1'b1;
          else if (apb.prdata_03[READY_BIT]) state_n = DT_SETUP;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          tmo_evt = 1'b1;
          err_evt = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  trng_rnd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (APB_DATA_WIDTH)
  ) u_fifo (
    .clk       (pclk_03),
    .rst       (preset_03),
    .push      (push),
    .push_data (apb.prdata_03),
    .pop       (rnd_ready),
    .head      (rnd_data),
    .valid     (rnd_valid),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_trng_apb_fetch_m03.sv
// Testbench for trng_apb_fetch_m03 with a scripted APB TRNG slave.
module tb_trng_apb_fetch_m03;
  import trng_apb_fetch_m03_pkg::*;

  logic        pclk_03;
  logic        preset_03;
  logic        fetch_en;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [2:0]  fifo_level;
  logic [7:0]  err_cnt;
  logic        timeout_o;

  trng_apb_fetch_m03_if apb ();

  trng_apb_fetch_m03 #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .pclk_03    (pclk_03),
    .preset_03  (preset_03),
    .fetch_en   (fetch_en),
    .apb        (apb),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .fifo_level (fifo_level),
    .err_cnt    (err_cnt),
    .timeout_o  (timeout_o)
  );

  initial pclk_03 = 1'b0;
  always #5 pclk_03 = ~pclk_03;

  // slave script
  int          cfg_st_err, cfg_st_zero, cfg_st_wait, cfg_dt_wait;
  logic        cfg_dt_err;
  logic [31:0] cfg_dt_base;
  int          st_xfers, dt_xfers, acc_cnt;
  logic        cnt_clr;

  int checks   = 0;
  int failures = 0;

  // STATUS: first cfg_st_err reads error out, next cfg_st_zero report not-ready,
  // then ready. DATA returns cfg_dt_base + index of the DATA read.
  always_comb begin
    apb.pready_03  = 1'b0;
    apb.pslverr_03 = 1'b0;
    apb.prdata_03  = '0;
    if (apb.psel_03 && apb.penable_03) begin
      if (apb.paddr_03 == STATUS_ADDR) begin
        apb.pready_03 = (acc_cnt >= cfg_st_wait);
        if (st_xfers < cfg_st_err) begin
          apb.pslverr_03 = 1'b1;
          apb.prdata_03  = 32'h0000_0001;
        end else if (st_xfers < cfg_st_err + cfg_st_zero) begin
          apb.prdata_03 = 32'hFFFF_FFFE;
        end else begin
          apb.prdata_03 = 32'h0000_0001;
        end
      end else begin
        apb.pready_03  = (acc_cnt >= cfg_dt_wait);
        apb.pslverr_03 = cfg_dt_err;
        apb.prdata_03  = cfg_dt_base + 32'(dt_xfers);
      end
    end
  end

  always @(posedge pclk_03) begin
    if (cnt_clr) begin
      st_xfers <= 0;
      dt_xfers <= 0;
    end else if (apb.psel_03 && apb.penable_03 && apb.pready_03) begin
      if (apb.paddr_03 == STATUS_ADDR) st_xfers <= st_xfers + 1;
      else                             dt_xfers <= dt_xfers + 1;
    end
    if (!(apb.psel_03 && apb.penable_03) || apb.pready_03) acc_cnt <= 0;
    else                                                    acc_cnt <= acc_cnt + 1;
  end

  typedef struct {
    int          st_err;
    int          st_zero;
    int          st_wait;
    int          dt_wait;
    logic        dt_err;
    logic [31:0] data;
    int          exp_st;
    int          exp_lvl;
    int          exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge pclk_03);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic doReset();
    preset_03 = 1'b1;
    fetch_en  = 1'b0;
    rnd_ready = 1'b0;
    cnt_clr   = 1'b1;
    tick();
    tick();
    preset_03 = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic setSlave(input int se, input int sz, input int sw, input int dw,
                          input logic de, input logic [31:0] base);
    cfg_st_err  = se;
    cfg_st_zero = sz;
    cfg_st_wait = sw;
    cfg_dt_wait = dw;
    cfg_dt_err  = de;
    cfg_dt_base = base;
  endtask

  // one fetch sequence: run until the DATA read completes, then stop
  task automatic applyStimulus(input vec_t v);
    doReset();
    setSlave(v.st_err, v.st_zero, v.st_wait, v.dt_wait, v.dt_err, v.data);
    fetch_en = 1'b1;
    for (int n = 0; n < 200 && dt_xfers < 1; n++) tick();
    fetch_en = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_word;

    //         st_err st_zero st_wait dt_wait dt_err data           exp_st lvl err
    vecs[0] = '{0,    0,      0,      0,      1'b0,  32'hA5A5_0001, 1,     1,  0};
    vecs[1] = '{0,    3,      0,      0,      1'b0,  32'h1234_5678, 4,     1,  0};
    vecs[2] = '{0,    0,      0,      0,      1'b1,  32'hDEAD_BEEF, 1,     0,  1};
    vecs[3] = '{2,    1,      2,      3,      1'b0,  32'hCAFE_F00D, 4,     1,  2};
    vecs[4] = '{1,    0,      0,      1,      1'b1,  32'h0BAD_0BAD, 2,     0,  2};

    setSlave(0, 0, 0, 0, 1'b0, 32'h0);
    doReset();
    preset_03 = 1'b1;
    #1;
    checkOutput("rst_psel",    32'(apb.psel_03),    32'd0);
    checkOutput("rst_penable", 32'(apb.penable_03), 32'd0);
    checkOutput("rst_paddr",   apb.paddr_03,        32'd0);
    checkOutput("rst_pwrite",  32'(apb.pwrite_03),  32'd0);
    checkOutput("rst_pstrb",   32'(apb.pstrb_03),   32'd0);
    checkOutput("rst_pprot",   32'(apb.pprot_03),   32'd0);
    checkOutput("rst_pwdata",  apb.pwdata_03,       32'd0);
    checkOutput("rst_valid",   32'(rnd_valid),      32'd0);
    checkOutput("rst_level",   32'(fifo_level),     32'd0);
    checkOutput("rst_errcnt",  32'(err_cnt),        32'd0);
    checkOutput("rst_timeout", 32'(timeout_o),      32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_st_xfers", i), 32'(st_xfers),   32'(vecs[i].exp_st));
      checkOutput($sformatf("v%0d_dt_xfers", i), 32'(dt_xfers),   32'd1);
      checkOutput($sformatf("v%0d_level", i),    32'(fifo_level), 32'(vecs[i].exp_lvl));
      checkOutput($sformatf("v%0d_valid", i),    32'(rnd_valid),  32'(vecs[i].exp_lvl));
      checkOutput($sformatf("v%0d_errcnt", i),   32'(err_cnt),    32'(vecs[i].exp_err));
      checkOutput($sformatf("v%0d_psel", i),     32'(apb.psel_03), 32'd0);
      if (vecs[i].exp_lvl != 0)
        checkOutput($sformatf("v%0d_data", i), rnd_data, vecs[i].data);
    end

    // first-word latency, fill to full, single pop refill, drain
    doReset();
    setSlave(0, 0, 0, 0, 1'b0, 32'hA5A5_0001);
    fetch_en = 1'b1;
    n = 0;
    while (!rnd_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("lat_cycles", 32'(n), 32'd5);
    checkOutput("lat_data",   rnd_data, 32'hA5A5_0001);
    repeat (40) tick();
    checkOutput("full_level", 32'(fifo_level),  32'd4);
    checkOutput("full_psel",  32'(apb.psel_03), 32'd0);
    checkOutput("full_dt",    32'(dt_xfers),    32'd4);
    checkOutput("full_head",  rnd_data,         32'hA5A5_0001);
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    checkOutput("pop_head",  rnd_data,         32'hA5A5_0002);
    checkOutput("pop_level", 32'(fifo_level),  32'd3);
    repeat (10) tick();
    checkOutput("refill_level", 32'(fifo_level),  32'd4);
    checkOutput("refill_dt",    32'(dt_xfers),    32'd5);
    checkOutput("refill_psel",  32'(apb.psel_03), 32'd0);
    checkOutput("refill_head",  rnd_data,         32'hA5A5_0002);
    fetch_en  = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_word = 32'hA5A5_0002 + 32'(i);
      checkOutput($sformatf("drain%0d", i), rnd_data, exp_word);
      tick();
    end
    checkOutput("drain_valid", 32'(rnd_valid),  32'd0);
    checkOutput("drain_level", 32'(fifo_level), 32'd0);
    tick();
    checkOutput("pop_empty_level", 32'(fifo_level), 32'd0);
    rnd_ready = 1'b0;

    // DATA access that never gets pready
    doReset();
    setSlave(0, 0, 0, 20, 1'b0, 32'h5EED_0000);
    fetch_en = 1'b1;
    n = 0;
    while (!(apb.psel_03 && apb.penable_03 && apb.paddr_03 == DATA_ADDR) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("tmo_reach_dt", 32'(n), 32'd4);
    n = 0;
    while (apb.penable_03 && n < 40) begin
      tick();
      n++;
    end
    fetch_en = 1'b0;
    checkOutput("tmo_cycles",  32'(n),             32'd16);
    checkOutput("tmo_flag",    32'(timeout_o),     32'd1);
    checkOutput("tmo_errcnt",  32'(err_cnt),       32'd1);
    checkOutput("tmo_level",   32'(fifo_level),    32'd0);
    checkOutput("tmo_psel",    32'(apb.psel_03),   32'd0);
    cfg_dt_wait = 0;
    fetch_en    = 1'b1;
    for (int k = 0; k < 30 && dt_xfers < 1; k++) tick();
    fetch_en = 1'b0;
    repeat (2) tick();
    checkOutput("rec_level",   32'(fifo_level), 32'd1);
    checkOutput("rec_data",    rnd_data,        32'h5EED_0000);
    checkOutput("rec_flag",    32'(timeout_o),  32'd1);
    checkOutput("rec_errcnt",  32'(err_cnt),    32'd1);

    // async reset in the middle of a STATUS access
    cfg_st_wait = 5;
    fetch_en    = 1'b1;
    n = 0;
    while (!(apb.psel_03 && apb.penable_03 && apb.paddr_03 == STATUS_ADDR) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("ar_in_st", 32'(apb.penable_03), 32'd1);
    preset_03 = 1'b1;
    #1;
    checkOutput("ar_psel",    32'(apb.psel_03),    32'd0);
    checkOutput("ar_penable", 32'(apb.penable_03), 32'd0);
    checkOutput("ar_level",   32'(fifo_level),     32'd0);
    checkOutput("ar_valid",   32'(rnd_valid),      32'd0);
    checkOutput("ar_errcnt",  32'(err_cnt),        32'd0);
    checkOutput("ar_timeout", 32'(timeout_o),      32'd0);
    cfg_st_wait = 0;
    tick();
    preset_03 = 1'b0;
    tick();
    checkOutput("restart_psel",    32'(apb.psel_03),    32'd1);
    checkOutput("restart_penable", 32'(apb.penable_03), 32'd0);
    checkOutput("restart_paddr",   apb.paddr_03,        STATUS_ADDR);
    fetch_en = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
